// File: rtl/ysyx_25010008_sram_if.sv
// AXI4-Lite bus bundle between the core's load/store or fetch master and the sram responder.
interface ysyx_25010008_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25010008_sram.sv
// AXI4-Lite word memory responder with independent read/write FSMs, fixed response latency,
// byte-lane write masking and DECERR on addresses outside [BASE, BASE + DEPTH*4).
module ysyx_25010008_sram #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 0
) (
  input logic                 clock,
  input logic                 reset,
  ysyx_25010008_sram_if.slave bus
);
  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] SizeBytes = 32'(DEPTH * 4);
  localparam logic [7:0]  Lat       = 8'(LATENCY);
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespDec   = 2'b11;

  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
  typedef enum logic [1:0] {WAddr, WWait, WResp} wr_state_e;

  // Not reset: contents survive reset.
  logic [31:0] mem [DEPTH];

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        commit;

  // Address decode; the 32-bit subtraction wraps so addresses below BASE land far out of range.
  logic [31:0]     rd_off, wr_off;
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic            rd_in_range, wr_in_range;
  assign rd_off      = rd_addr_q - BASE;
  assign wr_off      = aw_addr_q - BASE;
  assign rd_idx      = rd_off[IdxW+1:2];
  assign wr_idx      = wr_off[IdxW+1:2];
  assign rd_in_range = (rd_addr_q >= BASE) && (rd_off < SizeBytes);
  assign wr_in_range = (aw_addr_q >= BASE) && (wr_off < SizeBytes);

  logic aw_hs, w_hs;
  assign bus.arready = (rd_state_q == RIdle);
  assign bus.rvalid  = (rd_state_q == RResp);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = (wr_state_q == WAddr) && !aw_got_q;
  assign bus.wready  = (wr_state_q == WAddr) && !w_got_q;
  assign bus.bvalid  = (wr_state_q == WResp);
  assign bus.bresp   = bresp_q;
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid && bus.wready;

  // Read FSM next state: accept AR, count down latency, capture word, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RIdle: begin
        if (bus.arvalid) begin
          rd_addr_d  = bus.araddr;
          rd_cnt_d   = Lat;
          rd_state_d = RWait;
        end
      end
      RWait: begin
        if (rd_cnt_q == 8'd0) begin
          rdata_d    = rd_in_range ? mem[rd_idx] : 32'd0;
          rresp_d    = rd_in_range ? RespOkay : RespDec;
          rd_state_d = RResp;
        end else begin
          rd_cnt_d = rd_cnt_q - 8'd1;
        end
      end
      RResp: begin
        if (bus.rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  // Write FSM next state: collect AW and W in any order, count down, commit, hold until bready.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_cnt_d   = wr_cnt_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    case (wr_state_q)
      WAddr: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          aw_addr_d = bus.awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
        end
        if (aw_got_d && w_got_d) begin
          wr_cnt_d   = Lat;
          wr_state_d = WWait;
        end
      end
      WWait: begin
        if (wr_cnt_q == 8'd0) begin
          commit     = 1'b1;
          bresp_d    = wr_in_range ? RespOkay : RespDec;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = WResp;
        end else begin
          wr_cnt_d = wr_cnt_q - 8'd1;
        end
      end
      WResp: begin
        if (bus.bready) wr_state_d = WAddr;
      end
      default: wr_state_d = WAddr;
    endcase
  end

  // State registers for both FSMs; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RIdle;
      rd_addr_q  <= 32'd0;
      rd_cnt_q   <= 8'd0;
      rdata_q    <= 32'd0;
      rresp_q    <= RespOkay;
      wr_state_q <= WAddr;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      wr_cnt_q   <= 8'd0;
      bresp_q    <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_cnt_q   <= wr_cnt_d;
      bresp_q    <= bresp_d;
    end
  end

  // Masked array write; a read capturing on this same edge still sees the old word.
  always_ff @(posedge clock) begin
    if (commit && wr_in_range && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25010008_sram.sv
// Self-checking bench: one sram at LATENCY 0 and one at LATENCY 5, checked against a
// word-indexed reference memory and hand-derived timing.
module tb_ysyx_25010008_sram;
  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam int unsigned Depth = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_25010008_sram_if bus0 ();
  ysyx_25010008_sram_if bus5 ();

  ysyx_25010008_sram #(.BASE(Base), .DEPTH(Depth), .LATENCY(0)) u_dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (bus0.slave)
  );

  ysyx_25010008_sram #(.BASE(Base), .DEPTH(Depth), .LATENCY(5)) u_dut5 (
    .clock(clock),
    .reset(reset),
    .bus  (bus5.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] model [int unsigned];  // expected contents of u_dut0, keyed by word index

  function automatic bit addr_ok(input logic [31:0] a);
    longint x = longint'(a);
    return (x >= longint'(Base)) && (x < longint'(Base) + longint'(Depth) * 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m = old;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  task automatic idle_bus(input virtual ysyx_25010008_sram_if vif);
    vif.araddr = 32'd0; vif.arvalid = 1'b0; vif.rready = 1'b1;
    vif.awaddr = 32'd0; vif.awvalid = 1'b0; vif.wdata = 32'd0; vif.wstrb = 4'd0;
    vif.wvalid = 1'b0;  vif.bready = 1'b1;
  endtask

  // cyc counts negedges from the cycle the request is presented to the first one with bvalid.
  task automatic axi_write(input virtual ysyx_25010008_sram_if vif, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int cyc);
    @(negedge clock);
    vif.awaddr = a; vif.awvalid = 1'b1; vif.wdata = d; vif.wstrb = s; vif.wvalid = 1'b1;
    cyc = 0;
    @(negedge clock); cyc++;
    vif.awvalid = 1'b0; vif.wvalid = 1'b0;
    while (vif.bvalid !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    resp = vif.bresp;
    @(negedge clock);
  endtask

  task automatic axi_read(input virtual ysyx_25010008_sram_if vif, input logic [31:0] a,
                          output logic [31:0] d, output logic [1:0] resp, output int cyc);
    @(negedge clock);
    vif.araddr = a; vif.arvalid = 1'b1;
    cyc = 0;
    @(negedge clock); cyc++;
    vif.arvalid = 1'b0;
    while (vif.rvalid !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    d = vif.rdata; resp = vif.rresp;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [40:0] got0, got5;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    got0 = {bus0.arready, bus0.awready, bus0.wready, bus0.rvalid, bus0.bvalid,
            bus0.rresp, bus0.bresp, bus0.rdata};
    got5 = {bus5.arready, bus5.awready, bus5.wready, bus5.rvalid, bus5.bvalid,
            bus5.rresp, bus5.bresp, bus5.rdata};
    total++;
    if (got0 !== {5'b11100, 36'd0}) begin
      bad++; $display("FAIL reset_lat0: got %h want %h", got0, {5'b11100, 36'd0});
    end
    total++;
    if (got5 !== {5'b11100, 36'd0}) begin
      bad++; $display("FAIL reset_lat5: got %h want %h", got5, {5'b11100, 36'd0});
    end
  endtask

  task automatic test_word();
    logic [1:0] resp; logic [31:0] d; int cyc;
    axi_write(bus0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, cyc);
    model[4] = 32'hDEAD_BEEF;
    total++;
    if (resp !== 2'b00 || cyc != 2) begin
      bad++; $display("FAIL word_write: got resp=%b cyc=%0d want resp=00 cyc=2", resp, cyc);
    end
    axi_read(bus0, 32'h8000_0010, d, resp, cyc);
    total++;
    if (d !== 32'hDEAD_BEEF || resp !== 2'b00 || cyc != 2) begin
      bad++;
      $display("FAIL word_read: got %h/%b cyc=%0d want deadbeef/00 cyc=2", d, resp, cyc);
    end
  endtask

  task automatic test_byte_mask();
    logic [1:0] resp; logic [31:0] d; int cyc;
    axi_write(bus0, 32'h8000_0020, 32'h1122_3344, 4'hF, resp, cyc);
    axi_write(bus0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, resp, cyc);
    axi_read(bus0, 32'h8000_0020, d, resp, cyc);
    total++;
    if (d !== 32'h11BB_33DD || resp !== 2'b00) begin
      bad++; $display("FAIL byte_mask: got %h/%b want 11bb33dd/00", d, resp);
    end
    axi_write(bus0, 32'h8000_0022, 32'hFFFF_FFFF, 4'b0000, resp, cyc);
    total++;
    if (resp !== 2'b00) begin
      bad++; $display("FAIL zero_strb_resp: got %b want 00", resp);
    end
    axi_read(bus0, 32'h8000_0020, d, resp, cyc);
    model[8] = 32'h11BB_33DD;
    total++;
    if (d !== 32'h11BB_33DD) begin
      bad++; $display("FAIL zero_strb_data: got %h want 11bb33dd", d);
    end
  endtask

  // W alone at cycle 0, AW at cycle 3; wready stays low while waiting for AW.
  task automatic test_split(input virtual ysyx_25010008_sram_if vif, input int lat);
    logic [31:0] dat, d; logic [1:0] resp; int cyc;
    dat = $urandom;
    @(negedge clock);
    vif.wdata = dat; vif.wstrb = 4'hF; vif.wvalid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 1) vif.wvalid = 1'b0;
      total++;
      if (vif.wready !== 1'b0 || vif.awready !== 1'b1) begin
        bad++;
        $display("FAIL split_ready_l%0d_c%0d: got wready=%b awready=%b want 0 1", lat, c,
                 vif.wready, vif.awready);
      end
    end
    vif.awaddr = 32'h8000_0040; vif.awvalid = 1'b1;
    cyc = 0;
    @(negedge clock); cyc++;
    vif.awvalid = 1'b0;
    while (vif.bvalid !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    total++;
    if (cyc != 2 + lat || vif.bresp !== 2'b00) begin
      bad++;
      $display("FAIL split_bvalid_l%0d: got cyc=%0d resp=%b want cyc=%0d resp=00", lat, cyc,
               vif.bresp, 2 + lat);
    end
    @(negedge clock);
    axi_read(vif, 32'h8000_0040, d, resp, cyc);
    if (lat == 0) model[16] = dat;
    total++;
    if (d !== dat || cyc != 2 + lat) begin
      bad++;
      $display("FAIL split_read_l%0d: got %h cyc=%0d want %h cyc=%0d", lat, d, cyc, dat, 2 + lat);
    end
  endtask

  task automatic test_range();
    logic [1:0] resp; logic [31:0] d; int cyc;
    axi_read(bus0, 32'h7FFF_FFFC, d, resp, cyc);
    total++;
    if (d !== 32'd0 || resp !== 2'b11) begin
      bad++; $display("FAIL range_read_low: got %h/%b want 0/11", d, resp);
    end
    axi_read(bus0, Base + Depth * 4, d, resp, cyc);
    total++;
    if (d !== 32'd0 || resp !== 2'b11) begin
      bad++; $display("FAIL range_read_high: got %h/%b want 0/11", d, resp);
    end
    axi_write(bus0, Base, 32'hCAFE_F00D, 4'hF, resp, cyc);
    axi_write(bus0, Base + Depth * 4, 32'h0BAD_0BAD, 4'hF, resp, cyc);
    total++;
    if (resp !== 2'b11) begin
      bad++; $display("FAIL range_write_resp: got %b want 11", resp);
    end
    axi_read(bus0, Base, d, resp, cyc);
    model[0] = 32'hCAFE_F00D;
    total++;
    if (d !== 32'hCAFE_F00D || resp !== 2'b00) begin
      bad++; $display("FAIL range_word0: got %h/%b want cafef00d/00", d, resp);
    end
    axi_write(bus0, Base + Depth * 4 - 4, 32'h7654_3210, 4'hF, resp, cyc);
    axi_read(bus0, Base + Depth * 4 - 4, d, resp, cyc);
    model[Depth - 1] = 32'h7654_3210;
    total++;
    if (d !== 32'h7654_3210 || resp !== 2'b00) begin
      bad++; $display("FAIL range_last_word: got %h/%b want 76543210/00", d, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; int cyc;
    axi_write(bus0, 32'h8000_0050, 32'h0BAD_CAFE, 4'hF, resp, cyc);
    model[20] = 32'h0BAD_CAFE;
    @(negedge clock);
    bus0.rready = 1'b0; bus0.araddr = 32'h8000_0050; bus0.arvalid = 1'b1;
    cyc = 0;
    @(negedge clock); cyc++;
    bus0.arvalid = 1'b0;
    while (bus0.rvalid !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (bus0.rvalid !== 1'b1 || bus0.rdata !== 32'h0BAD_CAFE || bus0.rresp !== 2'b00) begin
        bad++;
        $display("FAIL stall_c%0d: got v=%b %h/%b want v=1 0badcafe/00", c, bus0.rvalid,
                 bus0.rdata, bus0.rresp);
      end
      @(negedge clock);
    end
    bus0.rready = 1'b1;
    @(negedge clock);
    total++;
    if (bus0.rvalid !== 1'b0) begin
      bad++; $display("FAIL stall_release: got rvalid=%b want 0", bus0.rvalid);
    end
  endtask

  // Read and write of one address presented together: capture and commit share an edge.
  task automatic test_hazard();
    logic [1:0] resp; logic [31:0] d; int cyc;
    axi_write(bus0, 32'h8000_0060, 32'h1234_5678, 4'hF, resp, cyc);
    @(negedge clock);
    bus0.awaddr = 32'h8000_0060; bus0.awvalid = 1'b1; bus0.wdata = 32'h5; bus0.wstrb = 4'hF;
    bus0.wvalid = 1'b1; bus0.araddr = 32'h8000_0060; bus0.arvalid = 1'b1;
    @(negedge clock);
    bus0.awvalid = 1'b0; bus0.wvalid = 1'b0; bus0.arvalid = 1'b0;
    @(negedge clock);
    total++;
    if (bus0.rvalid !== 1'b1 || bus0.bvalid !== 1'b1 || bus0.rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL hazard_old: got rv=%b bv=%b %h want 1 1 12345678", bus0.rvalid,
               bus0.bvalid, bus0.rdata);
    end
    @(negedge clock);
    axi_read(bus0, 32'h8000_0060, d, resp, cyc);
    model[24] = 32'h5;
    total++;
    if (d !== 32'h5) begin
      bad++; $display("FAIL hazard_new: got %h want 00000005", d);
    end
  endtask

  // arvalid held high with rready=1: handshakes every 3 cycles, rvalid 2 cycles later.
  task automatic test_back_to_back();
    logic [8:0] hs_mask, rv_mask; logic [1:0] resp; int cyc;
    hs_mask = '0; rv_mask = '0;
    axi_write(bus0, 32'h8000_0070, 32'h600D_F00D, 4'hF, resp, cyc);
    model[28] = 32'h600D_F00D;
    @(negedge clock);
    bus0.araddr = 32'h8000_0070; bus0.arvalid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clock);
      hs_mask[c] = bus0.arready;
      rv_mask[c] = bus0.rvalid;
      if (bus0.rvalid === 1'b1) begin
        total++;
        if (bus0.rdata !== 32'h600D_F00D) begin
          bad++; $display("FAIL b2b_data_c%0d: got %h want 600df00d", c, bus0.rdata);
        end
      end
    end
    bus0.arvalid = 1'b0;
    total++;
    if (hs_mask !== 9'b001_001_001 || rv_mask !== 9'b100_100_100) begin
      bad++;
      $display("FAIL b2b_timing: got hs=%b rv=%b want 001001001 100100100", hs_mask, rv_mask);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midflight(input virtual ysyx_25010008_sram_if vif, input int lat);
    logic [1:0] resp; logic [31:0] d; int cyc; bit seen_b;
    axi_write(vif, 32'h8000_0080, 32'h7777_0000, 4'hF, resp, cyc);
    if (lat == 0) model[32] = 32'h7777_0000;
    @(negedge clock);
    vif.awaddr = 32'h8000_0080; vif.awvalid = 1'b1; vif.wdata = 32'hFFFF_FFFF;
    vif.wstrb = 4'hF; vif.wvalid = 1'b1;
    @(negedge clock);
    vif.awvalid = 1'b0; vif.wvalid = 1'b0;
    repeat (lat / 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if ({vif.arready, vif.awready, vif.wready, vif.bvalid} !== 4'b1110) begin
      bad++;
      $display("FAIL midreset_ready_l%0d: got %b want 1110", lat,
               {vif.arready, vif.awready, vif.wready, vif.bvalid});
    end
    seen_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (vif.bvalid === 1'b1) seen_b = 1'b1;
    end
    total++;
    if (seen_b) begin
      bad++; $display("FAIL midreset_bvalid_l%0d: got bvalid=1 want 0", lat);
    end
    axi_read(vif, 32'h8000_0080, d, resp, cyc);
    total++;
    if (d !== 32'h7777_0000) begin
      bad++; $display("FAIL midreset_word_l%0d: got %h want 77770000", lat, d);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] d, a, dat; logic [3:0] s; int cyc, idx;
    bit oor, is_wr;
    for (int i = 0; i < 16; i++) begin
      dat = $urandom;
      axi_write(bus0, Base + 32'(400 + 4 * i), dat, 4'hF, resp, cyc);
      model[100 + i] = dat;
    end
    for (int n = 0; n < 60; n++) begin
      oor   = ($urandom_range(0, 9) == 0);
      is_wr = ($urandom_range(0, 1) == 1);
      idx   = 100 + $urandom_range(0, 15);
      dat   = $urandom;
      s     = 4'($urandom_range(0, 15));
      a     = Base + 32'(4 * idx) + 32'($urandom_range(0, 3));
      if (oor) begin
        a = $urandom;
        if (addr_ok(a)) a = Base - 32'd4;
      end
      if (is_wr) begin
        axi_write(bus0, a, dat, s, resp, cyc);
        if (!oor) model[idx] = merge(model[idx], dat, s);
        total++;
        if (resp !== (oor ? 2'b11 : 2'b00) || cyc != 2) begin
          bad++;
          $display("FAIL rand_write_%0d: addr %h got %b cyc=%0d want %b cyc=2", n, a, resp,
                   cyc, oor ? 2'b11 : 2'b00);
        end
      end else begin
        axi_read(bus0, a, d, resp, cyc);
        total++;
        if (d !== (oor ? 32'd0 : model[idx]) || resp !== (oor ? 2'b11 : 2'b00) || cyc != 2) begin
          bad++;
          $display("FAIL rand_read_%0d: addr %h got %h/%b cyc=%0d want %h/%b cyc=2", n, a, d,
                   resp, cyc, oor ? 32'd0 : model[idx], oor ? 2'b11 : 2'b00);
        end
      end
    end
  endtask

  initial begin
    idle_bus(bus0);
    idle_bus(bus5);
    test_reset();
    test_word();
    test_byte_mask();
    test_split(bus0, 0);
    test_split(bus5, 5);
    test_range();
    test_backpressure();
    test_hazard();
    test_back_to_back();
    test_reset_midflight(bus0, 0);
    test_reset_midflight(bus5, 5);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2000000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ysyx_25010008_sram.md
# ysyx_25010008_sram

AXI4-Lite responder holding a word-organised memory: the subordinate end of the load/store and instruction-fetch bus that the CPU's LSU drives. Independent read and write state machines accept address/data handshakes, wait a programmable fixed latency, then return R or B responses with byte-lane write masking and address-range error reporting. Sits directly behind the core's AXI4-Lite master, or behind an arbiter, in simulation and FPGA builds.

## Interface
- BASE, 32'h8000_0000: byte address of word 0.
- DEPTH, 4096: number of 32-bit words; power of two.
- LATENCY, 0: extra wait cycles between request acceptance and response (0..255).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane enables; bit i writes wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response, same encoding as rresp.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

## Operation
- Address decode: off = addr - BASE (32-bit wrap); in range iff addr >= BASE and off < DEPTH*4; index = off[log2(DEPTH)+1:2]; addr[1:0] ignored, with no lane shifting in either direction.
- Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, latch araddr and load counter with LATENCY; go to R_WAIT.
  - R_WAIT: arready=0. If counter==0, capture mem[index] (or 0 if out of range) into rdata, rresp = 00 or 11; go to R_RESP. Otherwise decrement.
  - R_RESP: rvalid=1; rdata and rresp held stable. On rready go to R_IDLE; rvalid drops that edge.
- Write FSM W_ADDR -> W_WAIT -> W_RESP -> W_ADDR.
  - W_ADDR: awready = !aw_got and wready = !w_got. AW and W are accepted in either order or in the same cycle, each latched into its own register. When both are held (including via the current handshake), load counter with LATENCY and go to W_WAIT.
  - W_WAIT: awready=wready=0. At counter==0, commit masked write (in range only), set bresp, clear aw_got/w_got, go to W_RESP; else decrement.
  - W_RESP: bvalid=1 until bready; then W_ADDR.
- Out-of-range write: no array change, bresp=11. wstrb=0 in range: no change, bresp=00.
- Read and write FSMs are fully independent; a read and a write may be outstanding simultaneously.
- The memory array is not reset; contents survive reset.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. Both FSMs return to idle; aw_got/w_got cleared; in-flight transactions are dropped with no response and no write.
- Read latency: AR handshake at edge E -> rvalid high after edge E+1+LATENCY. At LATENCY=0, rvalid is high 2 cycles after arvalid first rises with arready=1.
- Write latency: completing handshake (later of AW/W) at edge E -> array write and bvalid both at edge E+1+LATENCY.
- Same-edge hazard: a read capturing at the same edge a write commits returns the old word; a capture at any later edge returns the new word.
- Back-to-back: minimum read issue interval is 3+LATENCY cycles when rready is held 1; writes likewise.
- Response stalls: rvalid/bvalid remain asserted indefinitely with stable payload while rready/bready=0.

## Test plan
- Write/read word: AW 0x8000_0010 with W 0xDEADBEEF, strb 1111, same cycle -> bvalid 2 cycles later, bresp 00; read 0x8000_0010 -> rdata 0xDEADBEEF, rresp 00.
- Byte masking: preload 0x11223344, write 0xAABBCCDD strb 0101 -> read returns 0x11BB33DD.
- Split and reversed order: W at cycle 0, AW at cycle 3 -> wready=0 during cycles 1-3, bvalid exactly 2 cycles after AW handshake (LATENCY=0); repeat with LATENCY=5 -> 7 cycles.
- Range errors: read 0x7FFF_FFFC and BASE+DEPTH*4 -> rresp 11, rdata 0; write to BASE+DEPTH*4 -> bresp 11, word 0 unchanged.
- Backpressure and concurrency: hold rready=0 for 10 cycles -> rvalid/rdata stable; simultaneous write of 0x5 and read of the same address capturing on the commit edge -> old value; next read -> 0x5.
- Reset mid-transaction: assert reset in W_WAIT -> no bvalid, target word unchanged, all readys 1 the cycle after reset deasserts.
